serial_add_ctrl: RTL

- Controller that time-shares one single-bit full-adder cell to add two WIDTH-bit operands LSB-first, one bit per clock.
- Accepts operands through a valid/ready handshake and sequences the cell with a bit counter and carry flop.
- Returns a registered sum/carry-out through a valid/ready handshake.
- Sits between an operand producer and a result consumer as the area-minimal alternative to a parallel ripple adder.

---
 rtl/serial_add_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell shared across all bit positions,
// operands accepted and results returned over valid/ready handshakes.

module serial_add_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] s_sh_q;
    logic [WIDTH-1:0] s_sh_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fa_sum;
    logic             fa_cout;

    serial_add_fa u_fa (
        .a_i  (a_sh_q[0]),
        .b_i  (b_sh_q[0]),
        .c_i  (carry_q),
        .s_o  (fa_sum),
        .co_o (fa_cout)
    );

    // New sum bit enters at the MSB; the widened shift also covers WIDTH=1.
    assign s_sh_d = WIDTH'({fa_sum, s_sh_q} >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    s_sh_q  <= s_sh_d;
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        sum_q   <= s_sh_d;
                        cout_q  <= fa_cout;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
